// File: rtl/poly_voice_synth.sv
// poly_voice_synth: PS/2 scan-code driven polyphonic square-wave synth.
// Each held key owns one tone voice; active voices are mixed into a 1-bit
// delta-sigma speaker stream. Build option VOICE_STEAL_EN: when every voice
// is busy, a new press replaces the oldest voice instead of being dropped.
module poly_voice_synth #(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 20,
  parameter int AGE_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  code_valid,
  input  logic [7:0]            code_byte,
  output logic [7:0]            lut_key,
  input  logic [CNT_W-1:0]      lut_count,
  input  logic                  mute,
  output logic                  speaker,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  busy,
  output logic                  overflow
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W = $clog2(NUM_VOICES + 1);
  localparam int ACC_W = SUM_W + 1;

  localparam logic [1:0] PS_NORMAL    = 2'd0;
  localparam logic [1:0] PS_BREAK     = 2'd1;
  localparam logic [1:0] PS_EXT       = 2'd2;
  localparam logic [1:0] PS_EXT_BREAK = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]            ps, ps_next, fsm;
  logic                  accept, ev_fire, ev_is_press, ev_press;
  logic                  hit, free_ok, old_ok;
  logic [IDX_W-1:0]      hit_idx, free_idx, old_idx;
  logic [AGE_W-1:0]      old_age;
  logic [CNT_W-1:0]      cnt_p1;
  logic                  hit_p1, free_ok_p1;
  logic [IDX_W-1:0]      hit_idx_p1, free_idx_p1, old_idx_p1;
  logic                  do_load, do_rel, full_drop;
  logic [IDX_W-1:0]      tgt_idx;
  logic [7:0]            vkey   [NUM_VOICES];
  logic [CNT_W-1:0]      vcount [NUM_VOICES];
  logic [CNT_W-1:0]      vcnt   [NUM_VOICES];
  logic [AGE_W-1:0]      vage   [NUM_VOICES];
  logic [NUM_VOICES-1:0] wave, active;
  logic [SUM_W-1:0]      sum;
  logic [ACC_W-1:0]      acc, acc_sum;

  assign accept      = code_valid && (fsm == ST_IDLE);
  assign busy        = (fsm != ST_IDLE);
  assign active_mask = active;
  assign overflow    = full_drop;

  // A voice is sounding exactly while it holds a nonzero half-period.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_VOICES; i++) active[i] = (vcount[i] != '0);
  end

  // Scan-code prefix parser: decides the next state and whether a byte is an event.
  always_comb begin
    ps_next     = ps;
    ev_fire     = 1'b0;
    ev_is_press = 1'b0;
    case (ps)
      PS_NORMAL: begin
        if (code_byte == 8'hF0)      ps_next = PS_BREAK;
        else if (code_byte == 8'hE0) ps_next = PS_EXT;
        else begin
          ev_fire     = 1'b1;
          ev_is_press = 1'b1;
        end
      end
      PS_BREAK: begin
        ev_fire = 1'b1;
        ps_next = PS_NORMAL;
      end
      PS_EXT:  ps_next = (code_byte == 8'hF0) ? PS_EXT_BREAK : PS_NORMAL;
      default: ps_next = PS_NORMAL;
    endcase
  end

  // Parser state, event FSM and the latched event key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps       <= PS_NORMAL;
      fsm      <= ST_IDLE;
      lut_key  <= '0;
      ev_press <= 1'b0;
    end else begin
      if (accept) ps <= ps_next;
      case (fsm)
        ST_IDLE: begin
          if (accept && ev_fire) begin
            lut_key  <= code_byte;
            ev_press <= ev_is_press;
            fsm      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: fsm <= ST_COMMIT;
        default:   fsm <= ST_IDLE;
      endcase
    end
  end

  // Voice search: matching key, lowest free slot, oldest active slot (lowest index on ties).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    old_ok   = 1'b0;
    old_idx  = '0;
    old_age  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active[i] && (vkey[i] == lut_key) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!active[i] && !free_ok) begin
        free_ok  = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (active[i] && (!old_ok || (vage[i] > old_age))) begin
        old_ok  = 1'b1;
        old_idx = IDX_W'(i);
        old_age = vage[i];
      end
    end
  end

  // ---- stage p1: LOOKUP results, consumed only in COMMIT ----
  // Capture table result and search results during LOOKUP.
  always_ff @(posedge clk) begin
    if (fsm == ST_LOOKUP) begin
      cnt_p1      <= lut_count;
      hit_p1      <= hit;
      hit_idx_p1  <= hit_idx;
      free_ok_p1  <= free_ok;
      free_idx_p1 <= free_idx;
      old_idx_p1  <= old_idx;
    end
  end

  // COMMIT decision: allocate, steal, drop or release.
  always_comb begin
    do_load   = 1'b0;
    do_rel    = 1'b0;
    full_drop = 1'b0;
    tgt_idx   = free_ok_p1 ? free_idx_p1 : old_idx_p1;
    if (fsm == ST_COMMIT) begin
      if (ev_press) begin
        if (!hit_p1 && (cnt_p1 != '0)) begin
          if (free_ok_p1) begin
            do_load = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            do_load = 1'b1;
`else
            full_drop = 1'b1;
`endif
          end
        end
      end else if (hit_p1) begin
        do_rel = 1'b1;
      end
    end
  end

  // Voice bank: load/release from COMMIT takes priority over the tone counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vkey[i]   <= '0;
        vcount[i] <= '0;
        vcnt[i]   <= '0;
        vage[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_load && (tgt_idx == IDX_W'(i))) begin
          vkey[i]   <= lut_key;
          vcount[i] <= cnt_p1;
          vcnt[i]   <= '0;
          wave[i]   <= 1'b0;
          vage[i]   <= '0;
        end else if (do_rel && (hit_idx_p1 == IDX_W'(i))) begin
          vcount[i] <= '0;
          wave[i]   <= 1'b0;
        end else if (active[i]) begin
          if (vcnt[i] == vcount[i] - CNT_W'(1)) begin
            vcnt[i] <= '0;
            wave[i] <= ~wave[i];
          end else begin
            vcnt[i] <= vcnt[i] + CNT_W'(1);
          end
          if (do_load && (vage[i] != '1)) vage[i] <= vage[i] + AGE_W'(1);
        end else begin
          wave[i] <= 1'b0;
        end
      end
    end
  end

  // Number of sounding voices whose square wave is currently high.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + SUM_W'(wave[i] & active[i]);
  end

  assign acc_sum = acc + ACC_W'(sum);

  // First-order delta-sigma mixer with registered, mutable speaker output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      speaker <= 1'b0;
    end else if (acc_sum >= ACC_W'(NUM_VOICES)) begin
      acc     <= acc_sum - ACC_W'(NUM_VOICES);
      speaker <= !mute;
    end else begin
      acc     <= acc_sum;
      speaker <= 1'b0;
    end
  end
endmodule

// File: tb/tb_poly_voice_synth.sv
// Directed bench for poly_voice_synth (NUM_VOICES=4) with a small key table.
module tb_poly_voice_synth;
  localparam int NV = 4;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          code_valid = 1'b0;
  logic [7:0]    code_byte = 8'h00;
  logic [7:0]    lut_key;
  logic [CW-1:0] lut_count;
  logic          mute = 1'b0;
  logic          speaker;
  logic [NV-1:0] active_mask;
  logic          busy;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int ov_cnt  = 0;
  int spk_cnt = 0;

  poly_voice_synth #(.NUM_VOICES(NV), .CNT_W(CW), .AGE_W(8)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_byte(code_byte),
    .lut_key(lut_key), .lut_count(lut_count), .mute(mute), .speaker(speaker),
    .active_mask(active_mask), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // External note table model.
  always_comb begin
    case (lut_key)
      8'h1C:   lut_count = 20'h2EA85;
      8'h23:   lut_count = 20'h29B22;
      8'h34:   lut_count = 20'h23F3A;
      8'h2B:   lut_count = 20'h27A8E;
      8'h1D:   lut_count = 20'd3;
      8'h24:   lut_count = 20'h1F000;
      8'h2D:   lut_count = 20'd200;
      8'h2C:   lut_count = 20'd200;
      8'h15:   lut_count = 20'h1E000;
      default: lut_count = '0;
    endcase
  end

  always @(negedge clk) begin
    if (overflow) ov_cnt++;
    if (speaker)  spk_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Sends one byte and returns just after the edge that commits its event.
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1 code_valid = 1'b1; code_byte = b;
    @(posedge clk); #1 code_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, base_ov, base_spk, n;
    // reset state
    #1;
    check("rst_mask", 32'(active_mask), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_spk", 32'(speaker), 0);
    check("rst_ov", 32'(overflow), 0);
    check("rst_key", 32'(lut_key), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single note with latency
    base_spk = spk_cnt;
    @(posedge clk); #1 code_valid = 1'b1; code_byte = 8'h1C;
    @(posedge clk); #1 code_valid = 1'b0;
    check("lat_busy_t1", 32'(busy), 1);
    check("lat_mask_t1", 32'(active_mask), 0);
    check("lat_key", 32'(lut_key), 32'h1C);
    @(posedge clk); #1;
    check("lat_mask_t2", 32'(active_mask), 0);
    @(posedge clk); #1;
    check("lat_mask_t3", 32'(active_mask), 4'b0001);
    @(posedge clk); #1;
    check("lat_idle", 32'(busy), 0);
    send(8'hF0); send(8'h1C);
    check("single_rel", 32'(active_mask), 0);
    check("single_spk", 32'(spk_cnt - base_spk), 0);

    // chord and release
    do_reset();
    send(8'h1C); send(8'h23); send(8'h34);
    check("chord3", 32'(active_mask), 4'b0111);
    send(8'hF0); send(8'h23);
    check("chord_rel", 32'(active_mask), 4'b0101);
    send(8'h2B);
    check("chord_refill", 32'(active_mask), 4'b0111);
    check("chord_v1key", 32'(dut.vkey[1]), 32'h2B);

    // typematic repeat, unmapped key, unmatched release
    do_reset();
    base_ov = ov_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'h76);
    send(8'hF0); send(8'h15);
    check("repeat_mask", 32'(active_mask), 4'b0001);
    check("repeat_ov", 32'(ov_cnt - base_ov), 0);

    // E0 prefixed bytes produce no events
    send(8'hE0); send(8'h23); send(8'hE0); send(8'hF0); send(8'h1C);
    check("ext_noevent", 32'(active_mask), 4'b0001);

    // tone timing: count 3 => toggle 3 cycles after commit, 3 high, 3 low
    do_reset();
    send(8'h1D);
    k = 0;
    while (!dut.wave[0] && k < 20) begin @(posedge clk); #1; k++; end
    check("tone_first", 32'(k), 3);
    k = 0;
    while (dut.wave[0] && k < 20) begin @(posedge clk); #1; k++; end
    check("tone_high", 32'(k), 3);
    k = 0;
    while (!dut.wave[0] && k < 20) begin @(posedge clk); #1; k++; end
    check("tone_low", 32'(k), 3);

    // voice exhaustion
    do_reset();
    send(8'h1C); send(8'h23); send(8'h34); send(8'h2B);
    check("full_mask", 32'(active_mask), 4'b1111);
    base_ov = ov_cnt;
    send(8'h1D);
    @(posedge clk); #1;
    check("exh_mask", 32'(active_mask), 4'b1111);
    check("exh_v3key", 32'(dut.vkey[3]), 32'h2B);
`ifdef VOICE_STEAL_EN
    check("exh_ov", 32'(ov_cnt - base_ov), 0);
    check("exh_v0key", 32'(dut.vkey[0]), 32'h1D);
`else
    check("exh_ov", 32'(ov_cnt - base_ov), 1);
    check("exh_v0key", 32'(dut.vkey[0]), 32'h1C);
`endif

    // byte arriving while busy is dropped, parser stays in NORMAL
    do_reset();
    @(posedge clk); #1 code_valid = 1'b1; code_byte = 8'h1C;
    @(posedge clk); #1 code_byte = 8'hF0;
    @(posedge clk); #1 code_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_mask1", 32'(active_mask), 4'b0001);
    send(8'h23);
    check("drop_mask2", 32'(active_mask), 4'b0011);

    // mixer density with two waves high, then mute
    do_reset();
    send(8'h2D); send(8'h2C);
    k = 0;
    while (dut.wave[1:0] != 2'b11 && k < 600) begin @(negedge clk); k++; end
    check("mix_wait", 32'(k < 600), 1);
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      n = 0;
      for (int c = 0; c < 4; c++) begin @(negedge clk); if (speaker) n++; end
      check("mix_density", 32'(n), 2);
    end
    mute = 1'b1;
    @(posedge clk);
    n = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (speaker) n++; end
    check("mix_mute", 32'(n), 0);
    mute = 1'b0;

    // asynchronous reset mid-note and mid-event
    do_reset();
    send(8'h1C);
    @(posedge clk); #1 code_valid = 1'b1; code_byte = 8'h23;
    @(posedge clk); #1 code_valid = 1'b0;
    check("arst_busy_pre", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("arst_mask", 32'(active_mask), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_spk", 32'(speaker), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(8'h24);
    check("arst_realloc_mask", 32'(active_mask), 4'b0001);
    check("arst_realloc_key", 32'(dut.vkey[0]), 32'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
